// File: rtl/disaggregator_if.sv
// Handshake bundle for the disaggregator: FWFT sender side in, narrow receiver FIFO side out.
// The master modport is the disaggregator's view; slave is the surrounding FIFOs' view.
interface disaggregator_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4
);
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  modport master (
    input  sender_data,
    input  sender_empty_n,
    input  receiver_full_n,
    output sender_deq,
    output receiver_data,
    output receiver_enq
  );

  modport slave (
    output sender_data,
    output sender_empty_n,
    output receiver_full_n,
    input  sender_deq,
    input  receiver_data,
    input  receiver_enq
  );
endinterface

// File: rtl/disaggregator.sv
// Splits one wide FWFT word into FETCH_WIDTH narrow beats, lane 0 first.
// Define DISAGGREGATOR_PREFETCH_EN to reload on the last beat for bubble-free streaming.
module disaggregator #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  disaggregator_if.master bus
);
  localparam int unsigned     IdxW    = $clog2(FETCH_WIDTH);
  localparam logic [0:0]      StEmpty = 1'b0;
  localparam logic [0:0]      StSend  = 1'b1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FETCH_WIDTH - 1);

  logic [0:0]                             state_q, state_d;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [IdxW-1:0]                        idx_q, idx_d;
  logic                                   deq, enq;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    deq     = 1'b0;
    enq     = 1'b0;
    case (state_q)
      StEmpty: begin
        deq = bus.sender_empty_n;
        if (deq) begin
          buf_d   = bus.sender_data;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      default: begin
        enq = bus.receiver_full_n;
        if (enq) begin
          if (idx_q != LastIdx) begin
            idx_d = idx_q + 1'b1;
`ifdef DISAGGREGATOR_PREFETCH_EN
          end else if (bus.sender_empty_n) begin
            // Last beat overlaps the next load, so the FSM stays in SEND.
            deq   = 1'b1;
            buf_d = bus.sender_data;
            idx_d = '0;
`endif
          end else begin
            state_d = StEmpty;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  // Handshakes are masked during reset so nothing is popped or pushed while held.
  assign bus.sender_deq    = deq & ~rst;
  assign bus.receiver_enq  = enq & ~rst;
  assign bus.receiver_data = buf_q[idx_q];
endmodule

// File: tb/tb_disaggregator.sv
// Directed bench for disaggregator (DATA_WIDTH=16, FETCH_WIDTH=4) with a scoreboard queue;
// honours DISAGGREGATOR_PREFETCH_EN for the timing expectations.
module tb_disaggregator;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  disaggregator_if #(.DATA_WIDTH(16), .FETCH_WIDTH(4)) bus ();

  disaggregator #(.DATA_WIDTH(16), .FETCH_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] snd_q[$];
  logic [15:0] exp_q[$];
  int unsigned next_val;
  bit          stall_rand, bp_rand, deq_seen;
  int          first_deq_cyc, last_enq_cyc;
  bit          prev_valid, prev_full_n, prev_deq;
  logic [15:0] prev_data;

`ifdef DISAGGREGATOR_PREFETCH_EN
  localparam int StreamSpan = 64;
`else
  localparam int StreamSpan = 79;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wide word built from the running value counter, lane 0 = lowest value.
  task automatic push_word(input bit with_exp);
    logic [63:0] w;
    for (int i = 0; i < 4; i++) begin
      w[i*16 +: 16] = 16'(next_val + i);
      if (with_exp) exp_q.push_back(16'(next_val + i));
    end
    next_val += 4;
    snd_q.push_back(w);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 0);
  endtask

  // Sender FIFO model and receiver backpressure, updated just after each rising edge.
  initial begin
    bus.sender_data     = '0;
    bus.sender_empty_n  = 1'b0;
    bus.receiver_full_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (deq_seen && snd_q.size() != 0) void'(snd_q.pop_front());
      bus.sender_empty_n  = (snd_q.size() != 0) && !(stall_rand && $urandom_range(0, 3) == 0);
      bus.sender_data     = (snd_q.size() != 0) ? snd_q[0] : '0;
      bus.receiver_full_n = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops on enq, stability under backpressure.
  initial begin
    deq_seen   = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        deq_seen   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        deq_seen = bus.sender_deq;
        if (prev_valid && !prev_full_n && !prev_deq)
          check("rx_stable", 64'(bus.receiver_data), 64'(prev_data));
        if (bus.sender_deq && first_deq_cyc < 0) first_deq_cyc = cyc;
        if (bus.receiver_enq) begin
          last_enq_cyc = cyc;
          check("sb_pending", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("rx_data", 64'(bus.receiver_data), 64'(exp_q.pop_front()));
        end
        prev_valid  = 1'b1;
        prev_full_n = bus.receiver_full_n;
        prev_deq    = bus.sender_deq;
        prev_data   = bus.receiver_data;
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    rst           = 1'b0;
    stall_rand    = 1'b0;
    bp_rand       = 1'b0;
    next_val      = 1;
    first_deq_cyc = -1;
    last_enq_cyc  = -1;
    #1 rst = 1'b1;

    // Reset with sender non-empty and receiver ready: word 0x0004_0003_0002_0001 waits.
    push_word(1'b1);
    repeat (3) begin
      @(negedge clk);
      check("rst_deq", 64'(bus.sender_deq), 0);
      check("rst_enq", 64'(bus.receiver_enq), 0);
      check("rst_data", 64'(bus.receiver_data), 0);
    end
    @(posedge clk);
    #2 rst = 1'b0;

    // Single word: one deq, then four consecutive beats, then idle.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.sender_deq) found = 1'b1;
    end
    check("s2_deq_seen", 64'(found), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s2_beat_enq", 64'(bus.receiver_enq), 1);
      check("s2_beat_deq", 64'(bus.sender_deq), 0);
    end
    @(negedge clk);
    check("s2_after_enq", 64'(bus.receiver_enq), 0);
    check("s2_after_deq", 64'(bus.sender_deq), 0);
    wait_drain(10, "s2_drain");

    // Streaming 16 words carrying 0..63.
    next_val      = 0;
    first_deq_cyc = -1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) push_word(1'b1);
    wait_drain(200, "s3_drain");
    repeat (2) @(negedge clk);
    check("s3_span", 64'(last_enq_cyc - first_deq_cyc), 64'(StreamSpan));

    // Random backpressure and sender stalls for 2000 ns, then drain.
    stall_rand = 1'b1;
    bp_rand    = 1'b1;
    for (int k = 0; k < 40; k++) push_word(1'b1);
    repeat (200) @(negedge clk);
    stall_rand = 1'b0;
    bp_rand    = 1'b0;
    wait_drain(400, "s4_drain");
    repeat (2) @(negedge clk);
    check("s4_snd_empty", 64'(snd_q.size()), 0);

    // Reset after two beats; the partial word is discarded.
    next_val = 1;
    push_word(1'b1);
    push_word(1'b0);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (bus.receiver_enq) n++;
    end
    check("s5_two_beats", 64'(n), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(5 + i));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.receiver_enq) found = 1'b1;
    end
    check("s5_enq_seen", 64'(found), 1);
    check("s5_first_data", 64'(bus.receiver_data), 5);
    wait_drain(10, "s5_drain");
    repeat (2) @(negedge clk);

`ifdef DISAGGREGATOR_PREFETCH_EN
    // Sender empty on the last beat: fall back to EMPTY, deq when data returns.
    push_word(1'b1);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (bus.receiver_enq) n++;
    end
    check("s6_four_beats", 64'(n), 4);
    check("s6_last_deq", 64'(bus.sender_deq), 0);
    @(negedge clk);
    check("s6_empty_enq", 64'(bus.receiver_enq), 0);
    check("s6_empty_deq", 64'(bus.sender_deq), 0);
    @(negedge clk);
    push_word(1'b1);
    @(negedge clk);
    check("s6_deq_on_rise", 64'(bus.sender_deq), 1);
    check("s6_rise_enq", 64'(bus.receiver_enq), 0);
    @(negedge clk);
    check("s6_next_enq", 64'(bus.receiver_enq), 1);
    wait_drain(10, "s6_drain");
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
